// File: rtl/set_bits_allocator_pkg.sv
// Shared definitions for the set-bits allocator: width helper, FSM encoding, default timeout.
package set_bits_allocator_pkg;

    // Returns ceil(log2(value)) and is used to size count fields.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int TIMEOUT_CYC_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_t;

endpackage

// File: rtl/set_bits_allocator_if.sv
// Request/grant bundle of the set-bits allocator; master is the requester/consumer side.
interface set_bits_allocator_if
    import set_bits_allocator_pkg::*;
#(
    parameter int VEC_WIDTH = 4,
    parameter int CNT_WIDTH = log2(VEC_WIDTH + 1)
);
    logic                 req_valid;
    logic                 req_ready;
    logic [CNT_WIDTH-1:0] req_cnt;
    logic [VEC_WIDTH-1:0] avail;
    logic                 grant_valid;
    logic                 grant_ready;
    logic [VEC_WIDTH-1:0] grant_mask;
    logic                 grant_partial;

    modport master (
        output req_valid, req_cnt, avail, grant_ready,
        input  req_ready, grant_valid, grant_mask, grant_partial
    );

    modport slave (
        input  req_valid, req_cnt, avail, grant_ready,
        output req_ready, grant_valid, grant_mask, grant_partial
    );
endinterface

// File: rtl/lowest_n_select.sv
// Picks the lowest `count` set bits of avail: bit i survives when fewer than count set bits lie below it.
module lowest_n_select
    import set_bits_allocator_pkg::*;
#(
    parameter int VEC_WIDTH = 4,
    parameter int CNT_WIDTH = log2(VEC_WIDTH + 1)
) (
    input  logic [VEC_WIDTH-1:0] avail,
    input  logic [CNT_WIDTH-1:0] count,
    output logic [VEC_WIDTH-1:0] mask
);
    logic [CNT_WIDTH-1:0] prefix;

    always_comb begin
        prefix = '0;
        mask   = '0;
        for (int i = 0; i < VEC_WIDTH; i++) begin
            mask[i] = avail[i] && (prefix < count);
            prefix  = prefix + CNT_WIDTH'(avail[i]);
        end
    end
endmodule

// File: rtl/set_bits_counter.sv
// Combinational popcount of an IN_WIDTH-bit vector.
module set_bits_counter
    import set_bits_allocator_pkg::*;
#(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = log2(IN_WIDTH + 1)
) (
    input  logic [IN_WIDTH-1:0]  bits,
    output logic [OUT_WIDTH-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            count = count + OUT_WIDTH'(bits[i]);
        end
    end
endmodule

// File: rtl/set_bits_allocator.sv
// Claims N available bits lowest-index-first and hands them out through a registered grant.
// Optional partial grant after a WAIT timeout is enabled by defining ALLOC_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a request, count latched (clamped to VEC_WIDTH) on accept
// WAIT  | sampling avail each cycle until enough bits are free (or timeout)
// GRANT | grant_mask/grant_partial frozen, waiting for grant_ready
module set_bits_allocator
    import set_bits_allocator_pkg::*;
#(
    parameter int VEC_WIDTH   = 4,
    parameter int CNT_WIDTH   = log2(VEC_WIDTH + 1),
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic                 clk,
    input logic                 reset,
    set_bits_allocator_if.slave bus
);
    state_t               state;
    logic                 req_ready_q;
    logic                 grant_valid_q;
    logic [VEC_WIDTH-1:0] grant_mask_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_clamped;
    logic [CNT_WIDTH-1:0] pop;
    logic [VEC_WIDTH-1:0] sel_mask;
    logic                 satisfied;

    set_bits_counter #(
        .IN_WIDTH (VEC_WIDTH),
        .OUT_WIDTH(CNT_WIDTH)
    ) u_popcount (
        .bits (bus.avail),
        .count(pop)
    );

    // When popcount < count the selector already returns every available bit,
    // so the same mask serves the partial grant.
    lowest_n_select #(
        .VEC_WIDTH(VEC_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_select (
        .avail(bus.avail),
        .count(cnt_q),
        .mask (sel_mask)
    );

    always_comb begin
        cnt_clamped = bus.req_cnt;
        if (bus.req_cnt > CNT_WIDTH'(VEC_WIDTH)) cnt_clamped = CNT_WIDTH'(VEC_WIDTH);
        satisfied = (pop >= cnt_q);
    end

`ifdef ALLOC_TIMEOUT_EN
    localparam int TMO_WIDTH = log2(TIMEOUT_CYC + 1);

    logic [TMO_WIDTH-1:0] tmo_q;
    logic [TMO_WIDTH-1:0] tmo_next;
    logic                 grant_partial_q;

    assign tmo_next = tmo_q + TMO_WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_ready_q   <= 1'b1;
            grant_valid_q <= 1'b0;
            grant_mask_q  <= '0;
            cnt_q         <= '0;
`ifdef ALLOC_TIMEOUT_EN
            grant_partial_q <= 1'b0;
            tmo_q           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        cnt_q       <= cnt_clamped;
                        req_ready_q <= 1'b0;
                        state       <= WAIT;
`ifdef ALLOC_TIMEOUT_EN
                        tmo_q <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (satisfied) begin
                        grant_mask_q  <= sel_mask;
                        grant_valid_q <= 1'b1;
                        state         <= GRANT;
`ifdef ALLOC_TIMEOUT_EN
                        grant_partial_q <= 1'b0;
                    end else if (tmo_next == TMO_WIDTH'(TIMEOUT_CYC)) begin
                        grant_mask_q    <= sel_mask;
                        grant_valid_q   <= 1'b1;
                        grant_partial_q <= 1'b1;
                        state           <= GRANT;
                    end else begin
                        tmo_q <= tmo_next;
`endif
                    end
                end
                GRANT: begin
                    if (bus.grant_ready) begin
                        grant_valid_q <= 1'b0;
                        req_ready_q   <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    req_ready_q   <= 1'b1;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_mask  = grant_mask_q;
`ifdef ALLOC_TIMEOUT_EN
    assign bus.grant_partial = grant_partial_q;
`else
    assign bus.grant_partial = 1'b0;
`endif

endmodule

// File: tb/tb_set_bits_allocator.sv
// Directed bench for set_bits_allocator (VEC_WIDTH=4): vector table plus multi-cycle sequences.
module tb_set_bits_allocator;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    set_bits_allocator_if #(.VEC_WIDTH(4), .CNT_WIDTH(3)) bus ();

    set_bits_allocator #(
        .VEC_WIDTH  (4),
        .CNT_WIDTH  (3),
        .TIMEOUT_CYC(15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cnt;
        logic [3:0] av;
        logic [3:0] mask;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns in the first WAIT cycle.
    task automatic issue(input logic [2:0] cnt, input logic [3:0] av);
        chk("req_ready_before_issue", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_cnt   = cnt;
        bus.avail     = av;
        tick();
        bus.req_valid = 1'b0;
        chk("req_ready_in_wait", bus.req_ready, 1'b0);
    endtask

    initial begin
        vecs[0] = '{3'd2, 4'b1011, 4'b0011};
        vecs[1] = '{3'd0, 4'b1111, 4'b0000};
        vecs[2] = '{3'd6, 4'b1111, 4'b1111};
        vecs[3] = '{3'd7, 4'b1111, 4'b1111};
        vecs[4] = '{3'd1, 4'b1000, 4'b1000};
        vecs[5] = '{3'd3, 4'b1110, 4'b1110};
        vecs[6] = '{3'd2, 4'b0110, 4'b0110};
        vecs[7] = '{3'd4, 4'b1111, 4'b1111};
        vecs[8] = '{3'd1, 4'b0101, 4'b0001};
        vecs[9] = '{3'd3, 4'b1011, 4'b1011};

        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_cnt     = '0;
        bus.avail       = '0;
        bus.grant_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_grant_valid", bus.grant_valid, 1'b0);
        chk("reset_grant_mask", bus.grant_mask, 4'b0000);
        chk("reset_grant_partial", bus.grant_partial, 1'b0);
        tick();
        chk("reset_req_ready", bus.req_ready, 1'b1);

        // Table: grant at t+2, held until grant_ready, then back to IDLE.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].cnt, vecs[i].av);
            chk("vec_no_grant_t1", bus.grant_valid, 1'b0);
            tick();
            chk("vec_grant_valid", bus.grant_valid, 1'b1);
            chk("vec_grant_mask", bus.grant_mask, vecs[i].mask);
            chk("vec_grant_partial", bus.grant_partial, 1'b0);
            bus.grant_ready = 1'b1;
            tick();
            bus.grant_ready = 1'b0;
            chk("vec_release_valid", bus.grant_valid, 1'b0);
            chk("vec_release_ready", bus.req_ready, 1'b1);
        end

        // grant_ready already high when grant_valid rises: single-cycle grant.
        bus.grant_ready = 1'b1;
        issue(3'd2, 4'b1011);
        tick();
        chk("fast_grant_valid", bus.grant_valid, 1'b1);
        chk("fast_grant_mask", bus.grant_mask, 4'b0011);
        tick();
        chk("fast_release_valid", bus.grant_valid, 1'b0);
        chk("fast_release_ready", bus.req_ready, 1'b1);
        bus.grant_ready = 1'b0;

        // Not enough bits for five cycles, then enough.
        issue(3'd3, 4'b0101);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wait_no_grant", bus.grant_valid, 1'b0);
            chk("wait_req_ready", bus.req_ready, 1'b0);
        end
        bus.avail = 4'b1101;
        tick();
        chk("wait_grant_valid", bus.grant_valid, 1'b1);
        chk("wait_grant_mask", bus.grant_mask, 4'b1101);
        bus.grant_ready = 1'b1;
        tick();
        bus.grant_ready = 1'b0;
        chk("wait_release_ready", bus.req_ready, 1'b1);

        // Held grant: avail toggles and req_valid stays high, nothing changes.
        issue(3'd1, 4'b0010);
        tick();
        chk("hold_grant_mask0", bus.grant_mask, 4'b0010);
        bus.req_valid = 1'b1;
        bus.req_cnt   = 3'd2;
        for (int i = 0; i < 4; i++) begin
            bus.avail = (i % 2 == 0) ? 4'b1101 : 4'b0000;
            tick();
            chk("hold_grant_valid", bus.grant_valid, 1'b1);
            chk("hold_grant_mask", bus.grant_mask, 4'b0010);
            chk("hold_req_ready", bus.req_ready, 1'b0);
        end
        bus.grant_ready = 1'b1;
        tick();
        bus.grant_ready = 1'b0;
        chk("hold_release_valid", bus.grant_valid, 1'b0);
        chk("hold_release_ready", bus.req_ready, 1'b1);
        bus.avail = 4'b1111;
        tick();
        bus.req_valid = 1'b0;
        chk("hold_next_accepted", bus.req_ready, 1'b0);
        tick();
        chk("hold_next_grant_valid", bus.grant_valid, 1'b1);
        chk("hold_next_grant_mask", bus.grant_mask, 4'b0011);
        bus.grant_ready = 1'b1;
        tick();
        bus.grant_ready = 1'b0;

        // Reset for three cycles in the middle of WAIT drops the request.
        issue(3'd3, 4'b0000);
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("midwait_reset_valid", bus.grant_valid, 1'b0);
        chk("midwait_reset_mask", bus.grant_mask, 4'b0000);
        bus.avail = 4'b1111;
        tick();
        chk("midwait_reset_ready", bus.req_ready, 1'b1);
        tick();
        chk("midwait_no_stale_grant", bus.grant_valid, 1'b0);

        // Timeout behaviour with a fixed short avail.
        issue(3'd3, 4'b0110);
`ifdef ALLOC_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("tmo_no_grant_yet", bus.grant_valid, 1'b0);
        end
        tick();
        chk("tmo_grant_valid", bus.grant_valid, 1'b1);
        chk("tmo_grant_mask", bus.grant_mask, 4'b0110);
        chk("tmo_grant_partial", bus.grant_partial, 1'b1);
        bus.grant_ready = 1'b1;
        tick();
        bus.grant_ready = 1'b0;
        chk("tmo_release_ready", bus.req_ready, 1'b1);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("notmo_still_waiting", bus.grant_valid, 1'b0);
        end
        chk("notmo_req_ready", bus.req_ready, 1'b0);
        chk("notmo_partial", bus.grant_partial, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("notmo_after_reset_ready", bus.req_ready, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
